viterbi_frame_ctrl: RTL

VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

---
 rtl/viterbi_pkg.sv | 18 +
 rtl/viterbi_wdog.sv | 39 +++
 rtl/viterbi_frame_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared types and default parameters for the Viterbi frame controller.
// The optional watchdog is enabled with VITERBI_FRAME_CTRL_WDOG_EN.
package viterbi_pkg;

   localparam int unsigned K_DEF     = 4;
   localparam int unsigned D_DEF     = 24;
   localparam int unsigned LEN_W_DEF = 12;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      DATA,
      TAIL,
      FLUSH,
      DRAIN
   } state_e;

endpackage

// File: rtl/viterbi_wdog.sv
// DRAIN-phase watchdog for viterbi_frame_ctrl; built only with VITERBI_FRAME_CTRL_WDOG_EN.
// Raises expired when LIMIT cycles would pass with no kick while active.
`ifdef VITERBI_FRAME_CTRL_WDOG_EN
module viterbi_wdog #(
   parameter int unsigned LIMIT = 96
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic kick,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(LIMIT);
   // The owner registers its done/err response, so trip one cycle early.
   localparam logic [CNT_W-1:0] TRIP = CNT_W'(LIMIT - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!active || kick) begin
         cnt_d = '0;
      end else if (cnt_q != TRIP) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      expired = active && !kick && (cnt_q == TRIP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`endif

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer around a Viterbi decoder core: clear, data, tail, flush, drain.
// Define VITERBI_FRAME_CTRL_WDOG_EN to add the DRAIN-phase watchdog and err output.
module viterbi_frame_ctrl
   import viterbi_pkg::*;
#(
   parameter int unsigned K     = K_DEF,
   parameter int unsigned D     = D_DEF,
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic             in_sym_valid,
   output logic             in_sym_ready,
   input  logic [1:0]       in_sym,
   output logic             core_rst,
   output logic             core_sym_valid,
   input  logic             core_sym_ready,
   output logic [1:0]       core_sym,
   output logic             core_force_state0,
   input  logic             dec_bit_valid,
   input  logic             dec_bit,
   output logic             out_valid,
   output logic             out_bit,
   output logic             out_last
);

   localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
   localparam logic [LEN_W-1:0] TAIL_LAST = LEN_W'(K - 2);
   localparam logic [LEN_W-1:0] FLSH_LAST = LEN_W'(D - 1);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             done_q, done_d;
   logic             out_valid_q, out_valid_d;
   logic             out_bit_q, out_bit_d;
   logic             out_last_q, out_last_d;
   logic             bits_complete;
   logic             wdog_trip;

`ifdef VITERBI_FRAME_CTRL_WDOG_EN
   logic err_q, err_d;

   viterbi_wdog #(
      .LIMIT (4 * D)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .active  (state_q == DRAIN),
      .kick    (out_valid_q),
      .expired (wdog_trip)
   );

   assign err = err_q;
`else
   assign wdog_trip = 1'b0;
   assign err       = 1'b0;
`endif

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign core_rst  = rst || (state_q == CLR);
   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;
   assign out_last  = out_last_q;

   always_comb begin
      state_d           = state_q;
      len_d             = len_q;
      sym_cnt_d         = sym_cnt_q;
      bit_cnt_d         = bit_cnt_q;
      done_d            = 1'b0;
      out_valid_d       = 1'b0;
      out_bit_d         = out_bit_q;
      out_last_d        = 1'b0;
      in_sym_ready      = 1'b0;
      core_sym_valid    = 1'b0;
      core_sym          = 2'b00;
      core_force_state0 = 1'b0;
      bits_complete     = (bit_cnt_q == len_q);
`ifdef VITERBI_FRAME_CTRL_WDOG_EN
      err_d             = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
`ifdef VITERBI_FRAME_CTRL_WDOG_EN
               err_d = 1'b0;
`endif
               if (frame_len != '0) begin
                  len_d   = frame_len;
                  state_d = CLR;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         CLR: begin
            sym_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = DATA;
         end
         DATA, TAIL: begin
            in_sym_ready      = core_sym_ready;
            core_sym_valid    = in_sym_valid;
            core_sym          = in_sym;
            core_force_state0 = (state_q == TAIL);
            if (in_sym_valid && core_sym_ready) begin
               if (state_q == DATA && sym_cnt_q == len_q - ONE) begin
                  sym_cnt_d = '0;
                  state_d   = TAIL;
               end else if (state_q == TAIL && sym_cnt_q == TAIL_LAST) begin
                  sym_cnt_d = '0;
                  state_d   = FLUSH;
               end else begin
                  sym_cnt_d = sym_cnt_q + ONE;
               end
            end
         end
         FLUSH: begin
            core_sym_valid    = 1'b1;
            core_force_state0 = 1'b1;
            if (core_sym_ready) begin
               if (sym_cnt_q == FLSH_LAST) begin
                  sym_cnt_d = '0;
                  // Every bit may already be out; skip DRAIN entirely then.
                  if (bits_complete) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = DRAIN;
                  end
               end else begin
                  sym_cnt_d = sym_cnt_q + ONE;
               end
            end
         end
         DRAIN: begin
            if (bits_complete) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (wdog_trip) begin
`ifdef VITERBI_FRAME_CTRL_WDOG_EN
               err_d = 1'b1;
`endif
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Only the first frame_len decoded bits of a live frame reach the output.
      if ((state_q inside {DATA, TAIL, FLUSH, DRAIN}) && dec_bit_valid && (bit_cnt_q < len_q)) begin
         out_valid_d = 1'b1;
         out_bit_d   = dec_bit;
         out_last_d  = (bit_cnt_q == len_q - ONE);
         bit_cnt_d   = bit_cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         sym_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef VITERBI_FRAME_CTRL_WDOG_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         sym_cnt_q   <= sym_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_last_q  <= out_last_d;
`ifdef VITERBI_FRAME_CTRL_WDOG_EN
         err_q       <= err_d;
`endif
      end
   end

endmodule
